// File: rtl/arb_priority_8_if.sv
// arb_priority_8_if: request/grant bundle between the requesting agents (master)
// and the arbiter (slave).
interface arb_priority_8_if;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req, rel,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req, rel,
    output gnt, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/arb_priority_8.sv
// arb_priority_8: eight-requester arbiter with grant hold, release and forced timeout.
// Define ARB_ROUND_ROBIN_EN to replace fixed priority (bit 7 highest) with rotating priority.
module arb_priority_8 #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  arb_priority_8_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_gnt;
  logic [7:0]       w_gnt_nxt;
  logic [2:0]       r_gnt_id;
  logic [2:0]       w_gnt_id_nxt;
  logic             r_gnt_valid;
  logic             w_gnt_valid_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [2:0]       w_win_id;
  logic             w_req_any;
  logic             w_rel_normal;
  logic             w_hold_expired;

  assign w_req_any      = |bus.req;
  assign w_rel_normal   = bus.rel | ~bus.req[r_gnt_id];
  assign w_hold_expired = (r_cnt == CNT_W'(HOLD_MAX));

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] r_last;
  logic [2:0] w_cand;

  // Scan from lowest to highest priority so the last hit is the winner; last itself is lowest.
  always_comb begin
    w_win_id = r_last;
    w_cand   = r_last;
    for (int i = 8; i >= 1; i--) begin
      w_cand = r_last - 3'(i);
      if (bus.req[w_cand]) begin
        w_win_id = w_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 3'd0;
    end else if (r_state == IDLE && w_req_any) begin
      r_last <= w_win_id;
    end
  end
`else
  always_comb begin
    w_win_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req[i]) begin
        w_win_id = 3'(i);
      end
    end
  end
`endif

  // Normal release is tested before the hold limit so a coinciding rel suppresses timeout.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req_any) begin
          w_state_nxt     = GRANT;
          w_gnt_nxt       = 8'd1 << w_win_id;
          w_gnt_id_nxt    = w_win_id;
          w_gnt_valid_nxt = 1'b1;
          w_cnt_nxt       = CNT_W'(1);
        end
      end
      GRANT: begin
        if (w_rel_normal || w_hold_expired) begin
          w_state_nxt     = IDLE;
          w_gnt_nxt       = 8'd0;
          w_gnt_valid_nxt = 1'b0;
          w_timeout_nxt   = ~w_rel_normal;
          w_cnt_nxt       = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_gnt_nxt       = 8'd0;
        w_gnt_valid_nxt = 1'b0;
        w_cnt_nxt       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= 8'd0;
      r_gnt_id    <= 3'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_arb_priority_8.sv
// tb_arb_priority_8: directed and randomized checks of arb_priority_8 (HOLD_MAX=4)
// against a behavioural model of the arbitration rules.
module tb_arb_priority_8;

  localparam int HM = 4;

  logic clk;
  logic rst;
  logic checkEn;
  int   nChecks;
  int   nFail;

  arb_priority_8_if bus ();

  arb_priority_8 #(.HOLD_MAX(HM), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: whether someone holds the resource, who, for how long, and the pulse flag.
  bit mGranted;
  int mId;
  int mHeld;
  bit mTimeout;
  int mLast;

  function automatic int pickWinner(logic [7:0] r);
`ifdef ARB_ROUND_ROBIN_EN
    int c;
    for (int p = 1; p <= 8; p++) begin
      c = (mLast - p + 16) % 8;
      if (r[c]) return c;
    end
`else
    for (int c = 7; c >= 0; c--) begin
      if (r[c]) return c;
    end
`endif
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mGranted = 0;
      mId      = 0;
      mHeld    = 0;
      mTimeout = 0;
      mLast    = 0;
    end else begin
      mTimeout = 0;
      if (!mGranted) begin
        if (bus.req != 8'd0) begin
          mId      = pickWinner(bus.req);
          mLast    = mId;
          mGranted = 1;
          mHeld    = 1;
        end
      end else if (bus.rel || !bus.req[mId]) begin
        mGranted = 0;
      end else if (mHeld == HM) begin
        mGranted = 0;
        mTimeout = 1;
      end else begin
        mHeld++;
      end
    end
  end

  task automatic checkValue(string name, int actual, int expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    logic [7:0] expGnt;
    expGnt = mGranted ? (8'd1 << mId) : 8'd0;
    checkValue("model gnt", int'(bus.gnt), int'(expGnt));
    checkValue("model gnt_id", int'(bus.gnt_id), mId);
    checkValue("model gnt_valid", int'(bus.gnt_valid), int'(mGranted));
    checkValue("model timeout", int'(bus.timeout), int'(mTimeout));
  endtask

  // Compare process: outputs are registered, so the falling edge sees settled values.
  always @(negedge clk) begin
    if (checkEn && !rst) checkOutput();
  end

  task automatic applyStimulus(logic [7:0] r, logic l);
    @(negedge clk);
    bus.req = r;
    bus.rel = l;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst     = 1'b1;
    bus.req = 8'd0;
    bus.rel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    int         expRr[4];
    int         expTmoG[6];
    int         expTmoT[6];

    nChecks = 0;
    nFail   = 0;
    checkEn = 1'b0;
    rst     = 1'b1;
    bus.req = 8'd0;
    bus.rel = 1'b0;
    #1;
    checkValue("reset gnt", int'(bus.gnt), 0);
    checkValue("reset gnt_id", int'(bus.gnt_id), 0);
    checkValue("reset gnt_valid", int'(bus.gnt_valid), 0);
    checkValue("reset timeout", int'(bus.timeout), 0);
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    checkEn = 1'b1;

    $display("[TB] single request");
    applyStimulus(8'b0000_0000, 1'b0);
    applyStimulus(8'b0000_0100, 1'b0);
    checkValue("single pre gnt", int'(bus.gnt), 0);
    applyStimulus(8'b0000_0100, 1'b0);
    checkValue("single c2 gnt", int'(bus.gnt), 8'h04);
    checkValue("single c2 id", int'(bus.gnt_id), 2);
    applyStimulus(8'b0000_0100, 1'b0);
    checkValue("single c3 gnt", int'(bus.gnt), 8'h04);
    applyStimulus(8'b0000_0100, 1'b1);
    checkValue("single c4 gnt", int'(bus.gnt), 8'h04);
    applyStimulus(8'b0000_0000, 1'b0);
    checkValue("single c5 gnt", int'(bus.gnt), 0);
    checkValue("single c5 valid", int'(bus.gnt_valid), 0);
    checkValue("single c5 id kept", int'(bus.gnt_id), 2);

    $display("[TB] priority");
    doReset();
    applyStimulus(8'b1100_0010, 1'b0);
    applyStimulus(8'b1100_0010, 1'b0);
    checkValue("prio first id", int'(bus.gnt_id), 7);
    applyStimulus(8'b0100_0010, 1'b0);
    checkValue("prio hold id", int'(bus.gnt), 8'h80);
    applyStimulus(8'b0100_0010, 1'b0);
    checkValue("prio dead1", int'(bus.gnt_valid), 0);
    applyStimulus(8'b0000_0010, 1'b0);
    checkValue("prio second id", int'(bus.gnt_id), 6);
    applyStimulus(8'b0000_0010, 1'b0);
    checkValue("prio dead2", int'(bus.gnt), 0);
    applyStimulus(8'b0000_0000, 1'b0);
    checkValue("prio third id", int'(bus.gnt_id), 1);
    checkValue("prio third gnt", int'(bus.gnt), 8'h02);

    $display("[TB] timeout");
    doReset();
    expTmoG = '{1, 1, 1, 1, 0, 1};
    expTmoT = '{0, 0, 0, 0, 1, 0};
    applyStimulus(8'b0000_1000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(8'b0000_1000, 1'b0);
      checkValue("tmo valid", int'(bus.gnt_valid), expTmoG[k]);
      checkValue("tmo pulse", int'(bus.timeout), expTmoT[k]);
    end
    checkValue("tmo regrant id", int'(bus.gnt_id), 3);

    $display("[TB] release/timeout collision");
    doReset();
    applyStimulus(8'b0000_1000, 1'b0);
    applyStimulus(8'b0000_1000, 1'b0);
    applyStimulus(8'b0000_1000, 1'b0);
    applyStimulus(8'b0000_1000, 1'b0);
    applyStimulus(8'b0000_1000, 1'b1);
    checkValue("coll 4th grant", int'(bus.gnt_valid), 1);
    applyStimulus(8'b0000_0000, 1'b0);
    checkValue("coll released", int'(bus.gnt_valid), 0);
    checkValue("coll no timeout", int'(bus.timeout), 0);

    $display("[TB] rotation");
    doReset();
`ifdef ARB_ROUND_ROBIN_EN
    expRr = '{7, 0, 7, 0};
`else
    expRr = '{7, 7, 7, 7};
`endif
    applyStimulus(8'b1000_0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(8'b1000_0001, 1'b1);
      checkValue("rr grant id", int'(bus.gnt_id), expRr[k]);
      checkValue("rr grant valid", int'(bus.gnt_valid), 1);
      applyStimulus(8'b1000_0001, 1'b0);
      checkValue("rr dead", int'(bus.gnt_valid), 0);
    end

    $display("[TB] async reset");
    doReset();
    applyStimulus(8'b1000_0000, 1'b0);
    applyStimulus(8'b1000_0000, 1'b0);
    checkValue("areset pre gnt", int'(bus.gnt), 8'h80);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkValue("areset gnt", int'(bus.gnt), 0);
    checkValue("areset valid", int'(bus.gnt_valid), 0);
    checkValue("areset timeout", int'(bus.timeout), 0);
    @(negedge clk);
    bus.req = 8'b0000_0011;
    rst     = 1'b0;
    applyStimulus(8'b0000_0011, 1'b0);
    checkValue("areset regrant id", int'(bus.gnt_id), 1);

    $display("[TB] random");
    doReset();
    r = 8'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       r = 8'd0;
          1:       r = 8'd1 << $urandom_range(0, 7);
          default: r = 8'($urandom);
        endcase
      end
      applyStimulus(r, $urandom_range(0, 4) == 0);
    end
    applyStimulus(8'd0, 1'b0);
    @(negedge clk);
    checkEn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
